fft_sequencer: RTL and testbench
================================

# fft_sequencer

Control block that runs a complete in-place radix-2 DIT FFT/IFFT over a buffer in data memory, driving the shared butterfly unit one butterfly at a time. Sits beside the EX/MEM stages. A custom FFT instruction pulses `start`. While the transform runs, the sequencer owns the data-memory port and holds `busy` so the hazard unit stalls PC, IF/ID and ID/EX.

## Interface
- LOG2N, 3, log2 of transform length N (N = 8)
- ADDR_W, 5, data-memory word-address width
- DATA_W, 32, packed complex word: [31:16] real, [15:0] imag

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  one-cycle launch request from EX stage
- base_addr  in  ADDR_W  word address of element 0 of the buffer
- inverse  in  1  1 = IFFT (conjugate twiddles)
- busy  out  1  stall request to hazard unit
- done  out  1  one-cycle completion pulse
- mem_rena  out  1  data-memory read enable
- mem_wena  out  1  data-memory write enable
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_rdata  in  DATA_W  data-memory read data (combinational read)
- bf_valid  out  1  butterfly operands valid
- bf_ready  in  1  butterfly accepts operands
- bf_a, bf_b  out  DATA_W  butterfly operands
- bf_tw_idx  out  LOG2N-1  twiddle index k·2^(LOG2N-1-s)
- bf_inverse  out  1  latched `inverse`
- bf_out_valid  in  1  butterfly results valid
- bf_out_a, bf_out_b  in  DATA_W  butterfly results

## Operation
- The input buffer is already in bit-reversed order, placed there by software. The sequencer does no permutation.
- States: IDLE, RD_A, RD_B, ISSUE, WAIT, WR_A, WR_B, DONE.
- Counters:
  - stage s, range 0..LOG2N-1
  - butterfly b, range 0..N/2-1
- Address arithmetic:
  - half = 1<<s
  - k = b & (half-1)
  - idx_a = ((b>>s)<<(s+1)) + k
  - idx_b = idx_a + half
  - Memory address = base_addr + idx, truncated to ADDR_W. Wraps modulo 2^ADDR_W.
- IDLE: if `start`=1, latch base_addr and inverse, clear s and b, go to RD_A. Otherwise stay.
- RD_A: mem_rena=1, mem_addr=addr_a. Capture mem_rdata into the A register at the clock edge. Go to RD_B.
- RD_B: mem_rena=1, mem_addr=addr_b. Capture into the B register. Go to ISSUE.
- ISSUE: bf_valid=1. bf_a, bf_b and bf_tw_idx are held stable. Go to WAIT on the edge where bf_valid and bf_ready are both 1.
- WAIT: capture bf_out_a and bf_out_b when bf_out_valid=1, then go to WR_A. bf_out_valid is ignored in every other state.
- WR_A: mem_wena=1, addr_a, wdata = result A. Go to WR_B.
- WR_B: mem_wena=1, addr_b, wdata = result B. Then:
  - if b < N/2-1: b++, go to RD_A
  - else if s < LOG2N-1: b=0, s++, go to RD_A
  - else go to DONE
- DONE: done=1, busy=0, go to IDLE.
- busy=1 in every state except IDLE and DONE.
- `start` is ignored outside IDLE, including in DONE.
- mem_rena and mem_wena are never both 1. Both are 0 in IDLE, ISSUE, WAIT and DONE.

## Timing
- Reset, on any clk edge with rst=0, including mid-transform:
  - state returns to IDLE and all counters clear.
  - outputs: busy=0, done=0, mem_rena=0, mem_wena=0, bf_valid=0, mem_addr=0, mem_wdata=0, bf_a=0, bf_b=0, bf_tw_idx=0, bf_inverse=0.
  - Partially transformed memory is left as is.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Per-butterfly cost is 6 cycles minimum: 2 reads, ≥1 issue, ≥1 wait, 2 writes. Each cycle of bf_ready=0 or late bf_out_valid adds one cycle.
- Minimum latency is 6·(N/2)·LOG2N cycles from the edge that samples `start` to the first DONE cycle. For N=8 this is 72, so `done` is high in cycle 73.
- The pipeline resumes in the DONE cycle, because busy=0 there.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles -> every output reads 0. With rst=1 and no start, busy stays 0.
- Impulse: memory[0..7] = {0x00010000, 0, …, 0}, base_addr=0, inverse=0. Use an ideal butterfly model: bf_ready=1, results one cycle after handshake. Required:
  - all 8 words = 0x00010000
  - done high exactly 73 cycles after start
  - busy high for cycles 1..72
- Address sequence, stage 0: observed write pairs are (0,1), (2,3), (4,5), (6,7) with bf_tw_idx=0. In stage 2 they are (0,4), (1,5), (2,6), (3,7) with tw_idx 0..3.
- Backpressure: hold bf_ready=0 for 3 cycles on butterfly 2 -> bf_a, bf_b and bf_tw_idx are unchanged across the stall, and done is delayed by exactly 3 cycles (cycle 76).
- Wrap-around and inverse: base_addr=30, inverse=1 -> stage-0 first pair addresses are 30 and 31, the second pair is 0 and 1, and bf_inverse=1 throughout.
- Start while busy, then reset mid-operation:
  - A second start at cycle 10 is ignored, so done still lands at cycle 73.
  - Asserting rst=0 at cycle 40 gives busy=0 and state IDLE on the next edge, and no further memory writes occur.

Source files
------------

// File: rtl/fft_sequencer.sv
// Sequences an in-place radix-2 DIT FFT/IFFT over a bit-reversed buffer in data memory,
// feeding the shared butterfly unit one butterfly at a time while stalling the pipeline.
module fft_sequencer #(
    parameter int LOG2N  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              inverse,
    output logic              busy,
    output logic              done,
    output logic              mem_rena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [DATA_W-1:0] bf_a,
    output logic [DATA_W-1:0] bf_b,
    output logic [LOG2N-2:0]  bf_tw_idx,
    output logic              bf_inverse,
    input  logic              bf_out_valid,
    input  logic [DATA_W-1:0] bf_out_a,
    input  logic [DATA_W-1:0] bf_out_b
);

    localparam int HALF_N = 1 << (LOG2N - 1);
    localparam int BW     = LOG2N - 1;
    localparam int SW     = $clog2(LOG2N + 1);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, ISSUE, WAIT, WR_A, WR_B, DONE
    } state_t;

    state_t state, next_state;

    logic [SW-1:0]     stage;
    logic [BW-1:0]     bfly;
    logic [ADDR_W-1:0] base_q;
    logic              inv_q;
    logic [DATA_W-1:0] opa, opb, res_a, res_b;

    logic [LOG2N-1:0]  bfly_ext, half, kk, idx_a, idx_b, tw_full;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              last_bfly, last_stage;

    // Butterfly b of stage s pairs idx_a with idx_a + 2^s inside its group of 2^(s+1).
    always_comb begin
        bfly_ext   = {1'b0, bfly};
        half       = LOG2N'(1) << stage;
        kk         = bfly_ext & (half - LOG2N'(1));
        idx_a      = ((bfly_ext >> stage) << (stage + SW'(1))) + kk;
        idx_b      = idx_a + half;
        addr_a     = base_q + ADDR_W'(idx_a);
        addr_b     = base_q + ADDR_W'(idx_b);
        tw_full    = kk << (SW'(LOG2N - 1) - stage);
        last_bfly  = (bfly == BW'(HALF_N - 1));
        last_stage = (stage == SW'(LOG2N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RD_A;
            RD_A:    next_state = RD_B;
            RD_B:    next_state = ISSUE;
            ISSUE:   if (bf_ready) next_state = WAIT;
            WAIT:    if (bf_out_valid) next_state = WR_A;
            WR_A:    next_state = WR_B;
            WR_B:    next_state = (last_bfly && last_stage) ? DONE : RD_A;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode only registered state, so nothing from the inputs leaks through.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rena  = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bf_valid  = 1'b0;
        unique case (state)
            IDLE:  ;
            RD_A:  begin busy = 1'b1; mem_rena = 1'b1; mem_addr = addr_a; end
            RD_B:  begin busy = 1'b1; mem_rena = 1'b1; mem_addr = addr_b; end
            ISSUE: begin busy = 1'b1; bf_valid = 1'b1; end
            WAIT:  busy = 1'b1;
            WR_A:  begin busy = 1'b1; mem_wena = 1'b1; mem_addr = addr_a; mem_wdata = res_a; end
            WR_B:  begin busy = 1'b1; mem_wena = 1'b1; mem_addr = addr_b; mem_wdata = res_b; end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign bf_a       = opa;
    assign bf_b       = opb;
    assign bf_tw_idx  = tw_full[LOG2N-2:0];
    assign bf_inverse = inv_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage  <= '0;
            bfly   <= '0;
            base_q <= '0;
            inv_q  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            res_a  <= '0;
            res_b  <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    inv_q  <= inverse;
                    stage  <= '0;
                    bfly   <= '0;
                end
                RD_A: opa <= mem_rdata;
                RD_B: opb <= mem_rdata;
                WAIT: if (bf_out_valid) begin
                    res_a <= bf_out_a;
                    res_b <= bf_out_b;
                end
                WR_B: begin
                    if (!last_bfly) begin
                        bfly <= bfly + BW'(1);
                    end else if (!last_stage) begin
                        bfly  <= '0;
                        stage <= stage + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: memory and butterfly models, a loop-based
// reference FFT, a table of transform scenarios and hand-written reset sequences.
module tb_fft_sequencer;

    localparam int N     = 8;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic        inverse = 1'b0;
    logic        bf_ready = 1'b1;
    logic        bf_out_valid = 1'b0;
    logic [31:0] bf_out_a = '0;
    logic [31:0] bf_out_b = '0;

    logic        busy, done, mem_rena, mem_wena, bf_valid, bf_inverse;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, bf_a, bf_b;
    logic [1:0]  bf_tw_idx;

    logic [31:0] mem [32];
    logic [31:0] exp_mem [32];
    assign mem_rdata = mem[mem_addr];

    fft_sequencer #(.LOG2N(3), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .inverse(inverse),
        .busy(busy), .done(done), .mem_rena(mem_rena), .mem_wena(mem_wena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_a(bf_a), .bf_b(bf_b),
        .bf_tw_idx(bf_tw_idx), .bf_inverse(bf_inverse), .bf_out_valid(bf_out_valid),
        .bf_out_a(bf_out_a), .bf_out_b(bf_out_b)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] addr; logic [1:0] tw; } wr_t;
    typedef struct {
        logic [4:0] base;
        bit         inv;
        bit         impulse;
        bit         rnd_ready;
        int         out_delay;
        int         stall_len;
        int         extra_start;
        int         exp_done;
    } vec_t;

    wr_t wlog[$];
    wr_t elog[$];
    vec_t vecs[8];

    int n_cmp = 0;
    int n_fail = 0;
    int log_start;

    bit          rnd_ready, pend, prev_valid, exp_inv;
    bit          excl_ok, inv_ok, stable_ok;
    int          out_delay, stall_len, stall_used, hs_count, rem;
    logic [65:0] prev_op;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ideal complex butterfly with Q14 twiddles W8^tw; conjugated for the inverse.
    function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input int tw, input bit inv);
        int wr, wi, ar, ai, br, bi, pr, pi;
        case (tw)
            0:       begin wr = 16384;  wi = 0;      end
            1:       begin wr = 11585;  wi = -11585; end
            2:       begin wr = 0;      wi = -16384; end
            default: begin wr = -11585; wi = -11585; end
        endcase
        if (inv) wi = -wi;
        ar = int'($signed(a[31:16]));
        ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        pr = (br * wr - bi * wi) >>> 14;
        pi = (br * wi + bi * wr) >>> 14;
        return {16'(ar + pr), 16'(ai + pi), 16'(ar - pr), 16'(ai - pi)};
    endfunction

    // Reference transform: classic stage / group / element loops over the buffer.
    task automatic ref_fft(input logic [4:0] base, input bit inv);
        logic [63:0] r;
        logic [4:0]  aa, ab;
        for (int s = 0; s < 3; s++) begin
            int half = 1 << s;
            for (int j = 0; j < N; j += 2 * half) begin
                for (int k = 0; k < half; k++) begin
                    int tw = k * (N / (2 * half));
                    aa = 5'(int'(base) + j + k);
                    ab = 5'(int'(base) + j + k + half);
                    r = bfly(exp_mem[aa], exp_mem[ab], tw, inv);
                    exp_mem[aa] = r[63:32];
                    exp_mem[ab] = r[31:0];
                    elog.push_back({aa, 2'(tw)});
                    elog.push_back({ab, 2'(tw)});
                end
            end
        end
    endtask

    // One clock: memory writes, run monitors, butterfly responder and bf_ready driver.
    task automatic tick();
        @(negedge clk);
        if (mem_wena === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wlog.push_back({mem_addr, bf_tw_idx});
        end
        if (mem_rena === 1'b1 && mem_wena === 1'b1) excl_ok = 1'b0;
        if (busy === 1'b1 && bf_inverse !== exp_inv) inv_ok = 1'b0;
        if (bf_valid === 1'b1 && prev_valid && {bf_a, bf_b, bf_tw_idx} !== prev_op) stable_ok = 1'b0;
        prev_valid = (bf_valid === 1'b1);
        prev_op = {bf_a, bf_b, bf_tw_idx};
        if (bf_out_valid) begin
            bf_out_valid = 1'b0;
        end else if (pend) begin
            if (rem == 0) begin
                bf_out_valid = 1'b1;
                pend = 1'b0;
            end else begin
                rem--;
            end
        end
        if (bf_valid === 1'b1) begin
            if (hs_count == 2 && stall_used < stall_len) begin
                bf_ready = 1'b0;
                stall_used++;
            end else begin
                bf_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bf_ready) begin
                {bf_out_a, bf_out_b} = bfly(bf_a, bf_b, int'(bf_tw_idx), bf_inverse);
                pend = 1'b1;
                rem = out_delay;
                hs_count++;
            end
        end else begin
            bf_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {busy, done, mem_rena, mem_wena, bf_valid, bf_inverse}, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_bf_a"}, bf_a, 0);
        checkOutput({tag, "_bf_b"}, bf_b, 0);
        checkOutput({tag, "_bf_tw_idx"}, bf_tw_idx, 0);
    endtask

    task automatic prepRun(input vec_t v);
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        for (int i = 0; i < N; i++) begin
            logic [4:0] a = 5'(int'(v.base) + i);
            mem[a] = v.impulse ? ((i == 0) ? 32'h0001_0000 : 32'h0) : $urandom;
        end
        for (int i = 0; i < 32; i++) exp_mem[i] = mem[i];
        elog.delete();
        ref_fft(v.base, v.inv);
        log_start = wlog.size();
        rnd_ready = v.rnd_ready;
        out_delay = v.out_delay;
        stall_len = v.stall_len;
        stall_used = 0;
        hs_count = 0;
        pend = 1'b0;
        bf_out_valid = 1'b0;
        prev_valid = 1'b0;
        exp_inv = v.inv;
        excl_ok = 1'b1;
        inv_ok = 1'b1;
        stable_ok = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int  c;
        bit  busy_ok;
        int  outside_bad;
        prepRun(v);
        base_addr = v.base;
        inverse = v.inv;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = 5'($urandom);
        inverse = ~v.inv;
        c = 1;
        busy_ok = 1'b1;
        while (c <= LIMIT && done !== 1'b1) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (c == v.extra_start);
            tick();
            c++;
        end
        start = 1'b0;
        checkOutput("done_seen", done, 1);
        if (done !== 1'b1) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
        end else begin
            if (v.exp_done > 0) checkOutput("done_cycle", c, v.exp_done);
            checkOutput("busy_in_done", busy, 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            checkOutput("after_done_idle", {busy, done}, 0);
            tick();
        end
        checkOutput("busy_during_run", busy_ok, 1);
        checkOutput("rd_wr_exclusive", excl_ok, 1);
        checkOutput("bf_inverse_latched", inv_ok, 1);
        checkOutput("bf_operands_stable", stable_ok, 1);
        for (int i = 0; i < N; i++) begin
            logic [4:0] a = 5'(int'(v.base) + i);
            checkOutput($sformatf("mem[%0d]", a), mem[a], exp_mem[a]);
            if (v.impulse) checkOutput($sformatf("impulse_mem[%0d]", a), mem[a], 32'h0001_0000);
        end
        outside_bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) outside_bad++;
        checkOutput("mem_image_diffs", outside_bad, 0);
        checkOutput("write_count", wlog.size() - log_start, elog.size());
        for (int i = 0; i < elog.size() && log_start + i < wlog.size(); i++)
            checkOutput($sformatf("write[%0d]", i), wlog[log_start + i], elog[i]);
    endtask

    int st0_addr[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int st2_addr[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    int st2_tw[8]   = '{0, 0, 1, 1, 2, 2, 3, 3};
    int wrap_addr[4] = '{30, 31, 0, 1};

    initial begin
        vecs[0] = '{5'd0,  1'b0, 1'b1, 1'b0, 0, 0, 0,  73};
        vecs[1] = '{5'd0,  1'b0, 1'b0, 1'b0, 0, 3, 0,  76};
        vecs[2] = '{5'd30, 1'b1, 1'b0, 1'b0, 0, 0, 0,  73};
        vecs[3] = '{5'd5,  1'b0, 1'b0, 1'b1, 0, 0, 0,  0};
        vecs[4] = '{5'd17, 1'b1, 1'b0, 1'b0, 2, 0, 0,  97};
        vecs[5] = '{5'd11, 1'b1, 1'b0, 1'b1, 1, 0, 0,  0};
        vecs[6] = '{5'd3,  1'b0, 1'b0, 1'b0, 0, 0, 10, 73};
        vecs[7] = '{5'd26, 1'b1, 1'b1, 1'b0, 0, 0, 0,  73};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rnd_ready = 1'b0; out_delay = 0; stall_len = 0; stall_used = 0; hs_count = 0;
        pend = 1'b0; rem = 0; prev_valid = 1'b0; exp_inv = 1'b0;
        excl_ok = 1'b1; inv_ok = 1'b1; stable_ok = 1'b1; prev_op = '0;

        // Reset with a start request present must still leave everything at zero.
        rst = 1'b0;
        start = 1'b1;
        base_addr = 5'd21;
        inverse = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkAllZero("reset");
        rst = 1'b1;
        start = 1'b0;
        begin
            bit busy_seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (busy !== 1'b0) busy_seen = 1'b1;
            end
            checkOutput("idle_no_start_busy", busy_seen, 0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            if (i == 0) begin
                for (int j = 0; j < 8 && log_start + 16 + j < wlog.size(); j++) begin
                    checkOutput($sformatf("stage0_wr[%0d]", j), wlog[log_start + j], {5'(st0_addr[j]), 2'd0});
                    checkOutput($sformatf("stage2_wr[%0d]", j), wlog[log_start + 16 + j],
                                {5'(st2_addr[j]), 2'(st2_tw[j])});
                end
            end
            if (i == 2) begin
                for (int j = 0; j < 4 && log_start + j < wlog.size(); j++)
                    checkOutput($sformatf("wrap_wr[%0d]", j), wlog[log_start + j].addr, wrap_addr[j]);
            end
        end

        // Reset in the middle of a transform: back to idle, memory left alone.
        begin
            vec_t v = '{5'd9, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
            int          wsnap;
            int          diffs;
            bit          busy_seen;
            logic [31:0] snap [32];
            prepRun(v);
            base_addr = v.base;
            inverse = v.inv;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c < 40; c++) tick();
            checkOutput("busy_before_mid_reset", busy, 1);
            rst = 1'b0;
            tick();
            rst = 1'b1;
            checkAllZero("mid_reset");
            wsnap = wlog.size();
            for (int i = 0; i < 32; i++) snap[i] = mem[i];
            busy_seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (busy !== 1'b0) busy_seen = 1'b1;
            end
            diffs = 0;
            for (int i = 0; i < 32; i++) if (mem[i] !== snap[i]) diffs++;
            checkOutput("mid_reset_busy", busy_seen, 0);
            checkOutput("mid_reset_writes", wlog.size() - wsnap, 0);
            checkOutput("mid_reset_mem_diffs", diffs, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
